// File: rtl/cpu_sequencer_if.sv
// Program-ROM fetch port and CRT pixel stream shared by the sequencer and its environment.
interface cpu_sequencer_if;
    logic [7:0] prog_addr;
    logic [8:0] prog_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [5:0] pix_col;
    logic [2:0] pix_row;
    logic       pix_on;

    modport master (
        output prog_addr,
        input  prog_data,
        output pix_valid,
        input  pix_ready,
        output pix_col,
        output pix_row,
        output pix_on
    );

    modport slave (
        input  prog_addr,
        output prog_data,
        input  pix_valid,
        output pix_ready,
        input  pix_col,
        input  pix_row,
        input  pix_on
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Two-instruction CPU (noop/addx) that paces a CRT pixel stream and accumulates
// signal strength at sample cycles; each CRT cycle completes on a valid/ready handshake.
module cpu_sequencer #(
    parameter int unsigned NUM_CYCLES = 240,
    parameter int unsigned LINE_W     = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          prog_len,
    cpu_sequencer_if.master     bus,
    output logic signed [7:0]   reg_x,
    output logic signed [23:0]  strength,
    output logic                busy,
    output logic                done
);
    localparam int unsigned CYC_W = $clog2(NUM_CYCLES + 1);
    localparam int unsigned COL_W = 6;
    localparam int unsigned ROW_W = 3;
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_W - 1);
    localparam logic [COL_W-1:0] COL_SAMPLE = COL_W'(LINE_W / 2 - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(5);
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(NUM_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC1, EXEC2, FIN} state_t;

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [7:0]         len_q, len_d;
    logic [8:0]         ir_q, ir_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic signed [7:0]  x_q, x_d;
    logic signed [23:0] str_q, str_d;
    logic [7:0]         addr_q, addr_d;
    logic               valid_q, valid_d;
    logic               on_q, on_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               hs;
    logic signed [23:0] term;
    logic signed [8:0]  diff;

    assign bus.prog_addr = addr_q;
    assign bus.pix_valid = valid_q;
    assign bus.pix_col   = col_q;
    assign bus.pix_row   = row_q;
    assign bus.pix_on    = on_q;
    assign reg_x         = x_q;
    assign strength      = str_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            ir_q    <= '0;
            cyc_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= 8'sd1;
            str_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            on_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            ir_q    <= ir_d;
            cyc_q   <= cyc_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_q     <= x_d;
            str_q   <= str_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            on_q    <= on_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        ir_d    = ir_q;
        cyc_d   = cyc_q;
        col_d   = col_q;
        row_d   = row_q;
        x_d     = x_q;
        str_d   = str_q;
        addr_d  = addr_q;
        done_d  = done_q;
        term    = '0;
        hs      = valid_q && bus.pix_ready;

        // A completed CRT cycle advances the raster and samples strength with the pre-update X
        if ((state_q == EXEC1 || state_q == EXEC2) && hs) begin
            cyc_d = cyc_q + CYC_W'(1);
            term  = $signed(24'(cyc_q) + 24'd1) * $signed({{16{x_q[7]}}, x_q});
            if (col_q == COL_SAMPLE) begin
                str_d = str_q + term;
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    cyc_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    str_d   = '0;
                    x_d     = 8'sd1;
                    len_d   = prog_len;
                    done_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                // Past the end of the program the core idles on noops
                ir_d    = (pc_q < len_q) ? bus.prog_data : 9'd0;
                state_d = EXEC1;
            end
            EXEC1: begin
                if (hs) begin
                    if (cyc_q == CYC_LAST) begin
                        state_d = FIN;
                    end else if (ir_q[8]) begin
                        state_d = EXEC2;
                    end else begin
                        if (pc_q < len_q) begin
                            pc_d = pc_q + 8'd1;
                        end
                        state_d = FETCH;
                    end
                end
            end
            EXEC2: begin
                if (hs) begin
                    x_d     = x_q + $signed(ir_q[7:0]);
                    pc_d    = pc_q + 8'd1;
                    state_d = (cyc_q == CYC_LAST) ? FIN : FETCH;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == EXEC1) || (state_d == EXEC2);
        busy_d  = valid_d || (state_d == FETCH) || (state_d == WAIT);
        if (state_d == FIN) begin
            done_d = 1'b1;
        end
        addr_d  = (state_d == FETCH) ? pc_d : addr_q;
        diff    = $signed({3'b000, col_d}) - $signed({x_d[7], x_d});
        on_d    = valid_d && (diff >= -9'sd1) && (diff <= 9'sd1);
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: synchronous ROM model, pixel-stream monitor, scenario tasks.
module tb_cpu_sequencer;
    localparam int NOOP = 999;
    localparam int NP   = 146;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         prog_len = 8'd0;
    logic signed [7:0]  reg_x;
    logic signed [23:0] strength;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    cpu_sequencer_if bus();

    cpu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .prog_len (prog_len),
        .bus      (bus),
        .reg_x    (reg_x),
        .strength (strength),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [256];
    always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

    int sample_prog [NP] = '{
        15, -11, 6, -3, 5, -1, -8, 13, 4, NOOP, -1, 5, -1, 5, -1, 5, -1, 5, -1, -35,
        1, 24, -19, 1, 16, -11, NOOP, NOOP, 21, -15, NOOP, NOOP, -3, 9, 1, -3, 8, 1, 5, NOOP,
        NOOP, NOOP, NOOP, NOOP, -36, NOOP, 1, 7, NOOP, NOOP, NOOP, 2, 6, NOOP, NOOP, NOOP, NOOP, NOOP, 1, NOOP,
        NOOP, 7, 1, NOOP, -13, 13, 7, NOOP, 1, -33, NOOP, NOOP, NOOP, 2, NOOP, NOOP, NOOP, 8, NOOP, -1,
        2, 1, NOOP, 17, -9, 1, 1, -3, 11, NOOP, NOOP, 1, NOOP, 1, NOOP, NOOP, -13, -19, 1, 3,
        26, -30, 12, -1, 3, 1, NOOP, NOOP, NOOP, -9, 18, 1, 2, NOOP, NOOP, 9, NOOP, NOOP, NOOP, -1,
        2, -37, 1, 3, NOOP, 15, -21, 22, -6, 1, NOOP, 2, 1, NOOP, -10, NOOP, NOOP, 20, 1, 2,
        2, -6, -11, NOOP, NOOP, NOOP
    };

    // Pixel monitor: logs each handshake and counts output changes across stalls
    int                hs_cnt = 0;
    int                stall_err = 0;
    logic              stall_flag = 1'b0;
    logic [18:0]       snap = '0;
    logic signed [7:0] cap_x   [4096];
    logic              cap_on  [4096];
    logic [5:0]        cap_col [4096];
    logic [2:0]        cap_row [4096];
    logic              ref_on  [240];
    logic signed [7:0] ref_x   [240];

    always @(negedge clk) begin
        if (!rst) begin
            stall_flag = 1'b0;
        end else begin
            if (stall_flag && ({bus.pix_valid, bus.pix_col, bus.pix_row, bus.pix_on, reg_x} !== snap))
                stall_err++;
            stall_flag = 1'b0;
            if (bus.pix_valid && bus.pix_ready) begin
                cap_x[hs_cnt % 4096]   = reg_x;
                cap_on[hs_cnt % 4096]  = bus.pix_on;
                cap_col[hs_cnt % 4096] = bus.pix_col;
                cap_row[hs_cnt % 4096] = bus.pix_row;
                hs_cnt++;
            end else if (bus.pix_valid) begin
                snap = {bus.pix_valid, bus.pix_col, bus.pix_row, bus.pix_on, reg_x};
                stall_flag = 1'b1;
            end
        end
    end

    function automatic logic exp_on(input int c, input int xe);
        return (c - xe >= -1) && (c - xe <= 1);
    endfunction

    // Count stream deviations from a model where X is 1 before cycle `sw` and `xl` from then on
    function automatic int stream_errs(input int base, input int sw, input int xl);
        int e = 0;
        for (int n = 1; n <= 240; n++) begin
            int k  = (base + n - 1) % 4096;
            int xe = (n < sw) ? 1 : xl;
            if (cap_col[k] !== 6'((n - 1) % 40) || cap_row[k] !== 3'((n - 1) / 40) ||
                cap_on[k] !== exp_on((n - 1) % 40, xe) || cap_x[k] !== 8'(xe))
                e++;
        end
        return e;
    endfunction

    task automatic load_sample();
        for (int i = 0; i < 256; i++) rom[i] = 9'h132;
        for (int i = 0; i < NP; i++)
            rom[i] = (sample_prog[i] == NOOP) ? 9'h000 : {1'b1, 8'(sample_prog[i])};
    endtask

    task automatic run_prog(input logic [7:0] len, input bit rnd, output int base, output bit ok);
        @(posedge clk); #1;
        prog_len = len;
        start = 1'b1;
        base = hs_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bus.pix_ready = rnd ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, bus.pix_valid, bus.pix_on, bus.pix_col, bus.pix_row, bus.prog_addr} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {busy, done, bus.pix_valid, bus.pix_on, bus.pix_col, bus.pix_row, bus.prog_addr});
        end
        total++;
        if (reg_x !== 8'sd1 || strength !== 24'sd0) begin
            bad++;
            $display("FAIL reset_regs got x=%0d s=%0d want x=1 s=0", reg_x, strength);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, bus.pix_valid} !== 3'b000 || reg_x !== 8'sd1) begin
            bad++;
            $display("FAIL reset_release_idle got busy=%b done=%b valid=%b x=%0d want 0 0 0 1",
                     busy, done, bus.pix_valid, reg_x);
        end
    endtask

    task automatic test_small_prog();
        int base, e;
        bit ok;
        logic signed [7:0] want5 [5] = '{8'sd1, 8'sd1, 8'sd1, 8'sd4, 8'sd4};
        for (int i = 0; i < 256; i++) rom[i] = {1'b1, 8'd50};
        rom[0] = 9'h000;
        rom[1] = {1'b1, 8'd3};
        rom[2] = {1'b1, 8'hFB};
        run_prog(8'd3, 1'b0, base, ok);
        total++;
        if (ok !== 1'b1 || hs_cnt - base !== 240) begin
            bad++;
            $display("FAIL small_done got ok=%0d cycles=%0d want 1 240", ok, hs_cnt - base);
        end
        for (int n = 0; n < 5; n++) begin
            total++;
            if (cap_x[(base + n) % 4096] !== want5[n]) begin
                bad++;
                $display("FAIL small_x_cycle%0d got=%0d want=%0d", n + 1, cap_x[(base + n) % 4096], want5[n]);
            end
        end
        e = 0;
        for (int n = 6; n <= 240; n++) if (cap_x[(base + n - 1) % 4096] !== -8'sd1) e++;
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL small_x_tail got %0d bad cycles want 0", e);
        end
        e = 0;
        for (int n = 1; n <= 240; n++) begin
            int k = (base + n - 1) % 4096;
            int xe = (n <= 3) ? 1 : (n <= 5) ? 4 : -1;
            if (cap_col[k] !== 6'((n - 1) % 40) || cap_row[k] !== 3'((n - 1) / 40) ||
                cap_on[k] !== exp_on((n - 1) % 40, xe))
                e++;
        end
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL small_pixels got %0d bad pixels want 0", e);
        end
        total++;
        if (reg_x !== -8'sd1 || strength !== -24'sd720 || busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL small_final got x=%0d s=%0d busy=%b done=%b want -1 -720 0 1",
                     reg_x, strength, busy, done);
        end
    endtask

    task automatic test_sample_prog();
        int base;
        bit ok;
        logic [39:0] got_row, want_row;
        logic signed [7:0] want_x [6] = '{8'sd21, 8'sd19, 8'sd18, 8'sd21, 8'sd16, 8'sd18};
        load_sample();
        run_prog(8'(NP), 1'b0, base, ok);
        total++;
        if (ok !== 1'b1 || hs_cnt - base !== 240) begin
            bad++;
            $display("FAIL sample_done got ok=%0d cycles=%0d want 1 240", ok, hs_cnt - base);
        end
        total++;
        if (strength !== 24'sd13140) begin
            bad++;
            $display("FAIL sample_strength got=%0d want=13140", strength);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (cap_x[(base + 19 + 40 * i) % 4096] !== want_x[i]) begin
                bad++;
                $display("FAIL sample_x_cycle%0d got=%0d want=%0d", 20 + 40 * i,
                         cap_x[(base + 19 + 40 * i) % 4096], want_x[i]);
            end
        end
        for (int c = 0; c < 40; c++) begin
            got_row[c]  = cap_on[(base + c) % 4096];
            want_row[c] = ((c % 4) < 2);
        end
        total++;
        if (got_row !== want_row) begin
            bad++;
            $display("FAIL sample_row0 got=%h want=%h", got_row, want_row);
        end
        for (int n = 0; n < 240; n++) begin
            ref_on[n] = cap_on[(base + n) % 4096];
            ref_x[n]  = cap_x[(base + n) % 4096];
        end
    endtask

    task automatic test_stall();
        int base, e;
        bit ok;
        stall_err = 0;
        run_prog(8'(NP), 1'b1, base, ok);
        total++;
        if (ok !== 1'b1 || hs_cnt - base !== 240) begin
            bad++;
            $display("FAIL stall_done got ok=%0d cycles=%0d want 1 240", ok, hs_cnt - base);
        end
        e = 0;
        for (int n = 0; n < 240; n++) begin
            int k = (base + n) % 4096;
            if (cap_on[k] !== ref_on[n] || cap_x[k] !== ref_x[n] ||
                cap_col[k] !== 6'(n % 40) || cap_row[k] !== 3'(n / 40))
                e++;
        end
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL stall_stream got %0d differing pixels want 0", e);
        end
        total++;
        if (stall_err !== 0) begin
            bad++;
            $display("FAIL stall_stable got %0d changes during stalls want 0", stall_err);
        end
        total++;
        if (strength !== 24'sd13140) begin
            bad++;
            $display("FAIL stall_strength got=%0d want=13140", strength);
        end
    endtask

    task automatic test_wrap();
        int base, e;
        bit ok;
        logic [7:0] ops [3] = '{8'd127, 8'hFE, 8'd39};
        int         xf  [3] = '{-128, -1, 40};
        for (int t = 0; t < 3; t++) begin
            rom[0] = {1'b1, ops[t]};
            run_prog(8'd1, 1'b0, base, ok);
            total++;
            if (ok !== 1'b1 || reg_x !== 8'(xf[t])) begin
                bad++;
                $display("FAIL wrap_x_%0d got ok=%0d x=%0d want 1 %0d", t, ok, reg_x, xf[t]);
            end
            e = stream_errs(base, 3, xf[t]);
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL wrap_pixels_%0d got %0d bad pixels want 0", t, e);
            end
        end
    endtask

    task automatic test_busy_start();
        int base, e;
        bit ok;
        rom[0] = {1'b1, 8'd10};
        @(posedge clk); #1;
        prog_len = 8'd0;
        start = 1'b1;
        base = hs_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            start = (i == 5 || i == 50 || i == 301) ? 1'b1 : 1'b0;
            prog_len = start ? 8'd5 : 8'd0;
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        prog_len = 8'd0;
        total++;
        if (ok !== 1'b1 || hs_cnt - base !== 240) begin
            bad++;
            $display("FAIL busy_start_done got ok=%0d cycles=%0d want 1 240", ok, hs_cnt - base);
        end
        total++;
        if (strength !== 24'sd720 || reg_x !== 8'sd1 || bus.prog_addr !== 8'd0) begin
            bad++;
            $display("FAIL busy_start_final got s=%0d x=%0d addr=%0d want 720 1 0",
                     strength, reg_x, bus.prog_addr);
        end
        e = stream_errs(base, 1, 1);
        total++;
        if (e !== 0) begin
            bad++;
            $display("FAIL busy_start_pixels got %0d bad pixels want 0", e);
        end
    endtask

    task automatic test_reset_midrun();
        int base;
        bit ok;
        load_sample();
        @(posedge clk); #1;
        prog_len = 8'(NP);
        start = 1'b1;
        base = hs_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (hs_cnt - base >= 25) bus.pix_ready = 1'b0;
            if (hs_cnt - base >= 25 && bus.pix_valid) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (ok !== 1'b1 || strength !== 24'sd420) begin
            bad++;
            $display("FAIL midrun_reach got ok=%0d s=%0d want 1 420", ok, strength);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (bus.pix_valid !== 1'b0 || busy !== 1'b0 || reg_x !== 8'sd1 || strength !== 24'sd0) begin
            bad++;
            $display("FAIL midrun_reset got valid=%b busy=%b x=%0d s=%0d want 0 0 1 0",
                     bus.pix_valid, busy, reg_x, strength);
        end
        total++;
        if ({done, bus.pix_on, bus.pix_col, bus.pix_row, bus.prog_addr} !== 19'd0) begin
            bad++;
            $display("FAIL midrun_reset_outs got=%h want=0",
                     {done, bus.pix_on, bus.pix_col, bus.pix_row, bus.prog_addr});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus.pix_ready = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.prog_addr !== 8'd0) begin
            bad++;
            $display("FAIL midrun_hold_idle got busy=%b valid=%b addr=%0d want 0 0 0",
                     busy, bus.pix_valid, bus.prog_addr);
        end
        run_prog(8'd0, 1'b0, base, ok);
        total++;
        if (ok !== 1'b1 || strength !== 24'sd720) begin
            bad++;
            $display("FAIL midrun_recover got ok=%0d s=%0d want 1 720", ok, strength);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;
        bus.pix_ready = 1'b1;
        test_reset();
        test_small_prog();
        test_sample_prog();
        test_stall();
        test_wrap();
        test_busy_start();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL provide parameter NUM_CYCLES, default 240, total CRT cycles per run.
REQ-002 SHALL provide parameter LINE_W, default 40, pixels per CRT row.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle run request, sampled in IDLE only.
REQ-006 SHALL have port prog_len  input  8  instruction count, sampled at start.
REQ-007 SHALL have port prog_addr  output  8  program ROM address (instruction index).
REQ-008 SHALL have port prog_data  input  9  ROM word: bit8=1 addx, 0 noop; bits7:0 signed operand; valid one cycle after prog_addr.
REQ-009 SHALL have port pix_valid  output  1  pixel presented.
REQ-010 SHALL have port pix_ready  input  1  sink accepts pixel.
REQ-011 SHALL have port pix_col  output  6  column 0..LINE_W-1.
REQ-012 SHALL have port pix_row  output  3  row 0..5.
REQ-013 SHALL have port pix_on  output  1  sprite lit at this pixel.
REQ-014 SHALL have port reg_x  output  8  signed X register, current value.
REQ-015 SHALL have port strength  output  24  signed signal-strength accumulator.
REQ-016 SHALL have ports busy and done  output  1 each  run in progress / run finished (done held until next start).

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, EXEC1, EXEC2, FIN.
REQ-018 IDLE: on start=1 SHALL clear pc, cycle counter, strength, set X=1, clear done, go FETCH.
REQ-019 FETCH: SHALL drive prog_addr=pc, go WAIT; WAIT: SHALL register prog_data, go EXEC1; pix_valid=0 in both.
REQ-020 pc >= prog_len SHALL be treated as noop without changing pc (padding to NUM_CYCLES).
REQ-021 EXEC1/EXEC2 SHALL each be exactly one CRT cycle: pix_valid=1, hold all pixel outputs stable until pix_valid&pix_ready.
REQ-022 A CRT cycle SHALL advance only on handshake; pix_ready low SHALL stall indefinitely with no state change.
REQ-023 On EXEC1 handshake: noop SHALL pc+1, go FETCH; addx SHALL go EXEC2.
REQ-024 On EXEC2 handshake: X SHALL become X+operand, 8-bit two's-complement wrap; pc+1; go FETCH.
REQ-025 CRT cycle n (1-based) SHALL use X before any update completing in that cycle.
REQ-026 pix_col/pix_row SHALL be (n-1) mod LINE_W and (n-1)/LINE_W; counters SHALL not use division at runtime (column wraps 39->0, row increments).
REQ-027 pix_on SHALL be 1 iff |pix_col - X| <= 1, computed in 9-bit signed arithmetic (X=-1 lights col 0; X=40 lights col 39).
REQ-028 On handshake of cycles 20, 60, 100, 140, 180, 220 strength SHALL add n*X (signed, 24-bit).
REQ-029 After handshake of cycle NUM_CYCLES SHALL go FIN regardless of instruction mid-way (pending addx second half discarded).
REQ-030 FIN SHALL set done=1, busy=0, go IDLE next cycle; strength and reg_x SHALL hold.
REQ-031 busy SHALL be 1 in all states except IDLE and FIN; start while busy SHALL be ignored.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, pc=0, prog_addr=0, X=1, strength=0, cycle=0, pix_valid=0, pix_on=0, pix_col=0, pix_row=0, busy=0, done=0, including mid-run and mid-stall.
REQ-033 Outputs SHALL leave reset values only on the first rising edge after rst returns high and a start.

Verification
REQ-034 Reset mid-run with pix_valid=1, pix_ready=0 -> same cycle pix_valid=0, busy=0, reg_x=1, strength=0.
REQ-035 Program {noop, addx 3, addx -5}, pix_ready=1 -> X in cycles 1..5 = 1,1,1,4,4; reg_x=-1 after cycle 5; cycles 6..240 X=-1; done after 240 handshakes.
REQ-036 Standard 146-instruction sample program -> strength=13140, first row pix_on pattern 11001100110011001100110011001100110011 00 (cols 0..39).
REQ-037 pix_ready toggled randomly -> pixel stream identical to pix_ready=1 run; outputs stable during every stall.
REQ-038 addx 127 from X=1 -> reg_x=-128 (wrap); X=-1 -> pix_on only at col 0 each row.
REQ-039 start pulsed while busy, and prog_len=0 -> start ignored; prog_len=0 runs 240 noop cycles, strength=1*(20+60+100+140+180+220)=720.
